// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
// Shared definitions for the SRAM arbiter slice:
//   state_t      - arbiter FSM state encoding (S_IDLE, S_ACCESS, S_TURN)
//   DEF_*        - default address width, data width and strobe length
//   MAX_REQ      - largest supported requester count
//   gnt_to_idx() - converts a one-hot grant vector into a requester index
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_TURN   = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 20;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ACC_CYC = 2;
    localparam int MAX_REQ     = 4;

    // One-hot to index. A zero vector maps to index 0, so callers
    // should qualify the result with a non-zero grant.
    function automatic logic [1:0] gnt_to_idx(input logic [MAX_REQ-1:0] gnt);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (gnt[i]) begin
                idx = idx | 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin selector. The search begins at the requester
// after i_last_winner and walks upward with wrap-around; the first
// asserted request wins.
// Ports:
//   i_req           - per-requester request vector
//   i_last_winner   - index of the previous winner
//   o_winner_onehot - one-hot winner (all zero when nobody requests)
//   o_winner_idx    - winner index (0 when nobody requests)
//   o_valid         - at least one request is present
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_winner,
    output logic [N_REQ-1:0] o_winner_onehot,
    output logic [IDX_W-1:0] o_winner_idx,
    output logic             o_valid
);

    int cand;

    always_comb begin
        o_winner_onehot = '0;
        o_winner_idx    = '0;
        o_valid         = 1'b0;
        cand            = 0;
        // Offsets 1..N_REQ visit every requester once, the previous
        // winner last, which is what makes continuous requesters rotate.
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(i_last_winner) + off) % N_REQ;
            if (!o_valid && i_req[cand]) begin
                o_valid               = 1'b1;
                o_winner_idx          = IDX_W'(cand);
                o_winner_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one asynchronous SRAM port between N_REQ single-word requesters.
// Round-robin arbitration in IDLE, ACC_CYC cycles of active strobes in
// ACCESS, then one TURN cycle with all strobes released before the next
// arbitration.
//
// Handshake: a requester raises i_req with i_we_n/i_addr/i_wdata stable
// and holds them until o_gnt pulses for it. The request is accepted on
// the clock edge that samples it in IDLE; o_gnt marks that acceptance in
// the following cycle, after which the requester may drop or change its
// request. o_rvalid pulses in TURN for reads, with o_rdata valid then
// and held until the next read completes.
//
// Ports:
//   i_clk, i_rst_n        - clock, asynchronous active-low reset
//   i_req/i_we_n          - per-requester request and access type (0 = write)
//   i_addr/i_wdata        - packed per-requester address and write data
//   o_gnt/o_rvalid        - one-hot acceptance and read-data-valid pulses
//   o_rdata               - last word read
//   o_busy                - FSM not in IDLE
//   o_state               - FSM state, for observation
//   o_sram_*              - SRAM address, strobes and write-data drive
//   i_sram_rdata          - data from the SRAM pins
//
// All outputs are registers or decodes of registered state only.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_CYC = DEF_ACC_CYC
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_we_n,
    input  logic [N_REQ*ADDR_W-1:0] i_addr,
    input  logic [N_REQ*DATA_W-1:0] i_wdata,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]       o_rdata,
    output logic                    o_busy,
    output state_t                  o_state,
    output logic [ADDR_W-1:0]       o_sram_addr,
    output logic                    o_sram_we_n,
    output logic                    o_sram_oe_n,
    output logic                    o_sram_ce_n,
    output logic [DATA_W-1:0]       o_sram_wdata,
    output logic                    o_sram_wdata_oe,
    input  logic [DATA_W-1:0]       i_sram_rdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(ACC_CYC + 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    last_winner;
    logic [IDX_W-1:0]    cur_idx;
    logic                cur_we_n;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [N_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    logic                sel_we_n;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    logic                arb_take;
    logic                last_acc;
    logic [N_REQ-1:0]    cur_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req           (i_req),
        .i_last_winner   (last_winner),
        .o_winner_onehot (pick_onehot),
        .o_winner_idx    (pick_idx),
        .o_valid         (pick_valid)
    );

    // Steer the winner's request fields using the one-hot vector, which
    // avoids indexing with an out-of-range value for non-power-of-2 N_REQ.
    always_comb begin
        sel_we_n  = 1'b1;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_onehot[k]) begin
                sel_we_n  = i_we_n[k];
                sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign arb_take = (state == S_IDLE) && pick_valid;
    assign last_acc = (cnt == CNT_W'(ACC_CYC - 1));

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (last_acc) begin
                    state_nxt = S_TURN;
                end
            end
            S_TURN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Latched request, access counter, arbitration history, read data.
    // addr_q is only loaded on acceptance, so the SRAM address holds its
    // value through TURN and while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt         <= '0;
            last_winner <= IDX_W'(N_REQ - 1);
            cur_idx     <= '0;
            cur_we_n    <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
        end else begin
            if (arb_take) begin
                cnt         <= '0;
                last_winner <= pick_idx;
                cur_idx     <= pick_idx;
                cur_we_n    <= sel_we_n;
                addr_q      <= sel_addr;
                wdata_q     <= sel_wdata;
            end else if (state == S_ACCESS && !last_acc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == S_ACCESS && last_acc && cur_we_n) begin
                rdata_q <= i_sram_rdata;
            end
        end
    end

    assign cur_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << cur_idx;

    // Output decode from registered state only
    assign o_gnt           = (state == S_ACCESS && cnt == '0) ? cur_onehot : '0;
    assign o_rvalid        = (state == S_TURN && cur_we_n) ? cur_onehot : '0;
    assign o_rdata         = rdata_q;
    assign o_busy          = (state != S_IDLE);
    assign o_state         = state;
    assign o_sram_addr     = addr_q;
    assign o_sram_wdata    = wdata_q;
    assign o_sram_ce_n     = !(state == S_ACCESS);
    assign o_sram_we_n     = !(state == S_ACCESS && !cur_we_n);
    assign o_sram_oe_n     = !(state == S_ACCESS && cur_we_n);
    assign o_sram_wdata_oe = (state == S_ACCESS) && !cur_we_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Directed bench for sram_arbiter at N_REQ=3, ACC_CYC=2. Inputs are driven
// and outputs sampled on the falling clock edge; the DUT acts on the
// rising edge. A small SRAM model backs the read data.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int N   = 3;
    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int ACC = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N-1:0]    we_n;
    logic [N*AW-1:0] addr_bus;
    logic [N*DW-1:0] wdata_bus;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    state_t          st;
    logic [AW-1:0]   sram_addr;
    logic            sram_we_n;
    logic            sram_oe_n;
    logic            sram_ce_n;
    logic [DW-1:0]   sram_wdata;
    logic            sram_wdata_oe;
    logic [DW-1:0]   sram_rdata;

    sram_arbiter #(
        .N_REQ   (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ACC_CYC (ACC)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req           (req),
        .i_we_n          (we_n),
        .i_addr          (addr_bus),
        .i_wdata         (wdata_bus),
        .o_gnt           (gnt),
        .o_rvalid        (rvalid),
        .o_rdata         (rdata),
        .o_busy          (busy),
        .o_state         (st),
        .o_sram_addr     (sram_addr),
        .o_sram_we_n     (sram_we_n),
        .o_sram_oe_n     (sram_oe_n),
        .o_sram_ce_n     (sram_ce_n),
        .o_sram_wdata    (sram_wdata),
        .o_sram_wdata_oe (sram_wdata_oe),
        .i_sram_rdata    (sram_rdata)
    );

    // SRAM model: low address byte selects the word
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            mem[sram_addr[7:0]] <= sram_wdata;
        end
    end
    assign sram_rdata = mem[sram_addr[7:0]];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic w_n, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req[k]               = 1'b1;
        we_n[k]              = w_n;
        addr_bus[k*AW +: AW] = a;
        wdata_bus[k*DW +: DW] = d;
    endtask

    task automatic clr_req(input int k);
        req[k] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) begin
            tick();
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [AW-1:0] a_tab [3];
    int            n_gnt;
    int            prev_c;
    logic [1:0]    g_idx;
    logic [1:0]    e_idx;
    logic [N-1:0]  seen;

    initial begin
        req       = '0;
        we_n      = '1;
        addr_bus  = '0;
        wdata_bus = '0;
        a_tab[0]  = 20'h00100;
        a_tab[1]  = 20'h00201;
        a_tab[2]  = 20'h00302;

        #1 rst_n = 1'b0;
        tick();
        tick();
        // reset values
        chk("rst_gnt",      32'(gnt), 32'd0);
        chk("rst_rvalid",   32'(rvalid), 32'd0);
        chk("rst_rdata",    32'(rdata), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_addr",     32'(sram_addr), 32'd0);
        chk("rst_we_n",     32'(sram_we_n), 32'd1);
        chk("rst_oe_n",     32'(sram_oe_n), 32'd1);
        chk("rst_ce_n",     32'(sram_ce_n), 32'd1);
        chk("rst_wdata",    32'(sram_wdata), 32'd0);
        chk("rst_wdata_oe", 32'(sram_wdata_oe), 32'd0);
        chk("rst_state",    32'(st), 32'(S_IDLE));
        rst_n = 1'b1;
        tick();

        // ---- write from req0 ----
        set_req(0, 1'b0, 20'h07D00, 16'h1234);
        tick(); // T+1
        chk("wr_gnt",      32'(gnt), 32'b001);
        chk("wr_we_n",     32'(sram_we_n), 32'd0);
        chk("wr_oe_n",     32'(sram_oe_n), 32'd1);
        chk("wr_ce_n",     32'(sram_ce_n), 32'd0);
        chk("wr_addr",     32'(sram_addr), 32'h07D00);
        chk("wr_wdata",    32'(sram_wdata), 32'h1234);
        chk("wr_wdata_oe", 32'(sram_wdata_oe), 32'd1);
        chk("wr_busy",     32'(busy), 32'd1);
        clr_req(0);
        tick(); // T+2
        chk("wr_gnt2",     32'(gnt), 32'd0);
        chk("wr_we_n2",    32'(sram_we_n), 32'd0);
        chk("wr_ce_n2",    32'(sram_ce_n), 32'd0);
        tick(); // T+3 TURN
        chk("wr_turn_st",  32'(st), 32'(S_TURN));
        chk("wr_turn_we",  32'(sram_we_n), 32'd1);
        chk("wr_turn_ce",  32'(sram_ce_n), 32'd1);
        chk("wr_turn_oe",  32'(sram_wdata_oe), 32'd0);
        chk("wr_turn_adr", 32'(sram_addr), 32'h07D00);
        chk("wr_turn_rv",  32'(rvalid), 32'd0);
        tick(); // T+4
        chk("wr_idle",     32'(busy), 32'd0);
        chk("wr_idle_adr", 32'(sram_addr), 32'h07D00);
        chk("wr_idle_ce",  32'(sram_ce_n), 32'd1);

        // ---- read from req1 ----
        set_req(1, 1'b1, 20'h07D00, 16'h0000);
        tick(); // T+1
        chk("rd_gnt",      32'(gnt), 32'b010);
        chk("rd_oe_n1",    32'(sram_oe_n), 32'd0);
        chk("rd_we_n1",    32'(sram_we_n), 32'd1);
        chk("rd_wdoe1",    32'(sram_wdata_oe), 32'd0);
        clr_req(1);
        tick(); // T+2
        chk("rd_oe_n2",    32'(sram_oe_n), 32'd0);
        chk("rd_rv2",      32'(rvalid), 32'd0);
        tick(); // T+3
        chk("rd_rvalid",   32'(rvalid), 32'b010);
        chk("rd_rdata",    32'(rdata), 32'h1234);
        chk("rd_oe_n3",    32'(sram_oe_n), 32'd1);
        tick(); // T+4
        chk("rd_rv4",      32'(rvalid), 32'd0);
        chk("rd_idle",     32'(busy), 32'd0);

        // ---- req2 arrives while req0 access in flight ----
        set_req(0, 1'b0, 20'h00010, 16'hBEEF);
        tick(); // T+1
        chk("lt_gnt0",     32'(gnt), 32'b001);
        clr_req(0);
        set_req(2, 1'b1, 20'h00020, 16'h0000);
        tick(); // T+2
        chk("lt_gnt_t2",   32'(gnt), 32'd0);
        tick(); // T+3
        chk("lt_gnt_t3",   32'(gnt), 32'd0);
        tick(); // T+4 idle
        chk("lt_gnt_t4",   32'(gnt), 32'd0);
        chk("lt_idle_t4",  32'(busy), 32'd0);
        tick(); // T+5
        chk("lt_gnt2",     32'(gnt), 32'b100);
        chk("lt_addr2",    32'(sram_addr), 32'h00020);
        clr_req(2);
        wait_idle();

        // ---- all three continuous: order 0,1,2,0,1,2, 4 cycles apart ----
        for (int k = 0; k < N; k++) begin
            set_req(k, 1'b1, a_tab[k], 16'h0000);
        end
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(2'd0);
            exp_q.push_back(2'd1);
            exp_q.push_back(2'd2);
        end
        n_gnt  = 0;
        prev_c = 0;
        for (int c = 1; c <= 40 && n_gnt < 6; c++) begin
            tick();
            if (gnt != '0) begin
                g_idx = gnt_to_idx(4'(gnt));
                e_idx = exp_q.pop_front();
                chk("rr_onehot", 32'($onehot(gnt)), 32'd1);
                chk("rr_order",  32'(g_idx), 32'(e_idx));
                chk("rr_addr",   32'(sram_addr), 32'(a_tab[e_idx]));
                if (n_gnt > 0) begin
                    chk("rr_gap", 32'(c - prev_c), 32'd4);
                end
                prev_c = c;
                n_gnt++;
            end
        end
        req = '0;
        chk("rr_count", 32'(n_gnt), 32'd6);
        wait_idle();

        // ---- reset during second ACCESS cycle of a write ----
        set_req(1, 1'b0, 20'h00030, 16'h5555);
        tick(); // T+1
        chk("rs_gnt",      32'(gnt), 32'b010);
        clr_req(1);
        tick(); // T+2
        chk("rs_we_pre",   32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rs_we_n",     32'(sram_we_n), 32'd1);
        chk("rs_ce_n",     32'(sram_ce_n), 32'd1);
        chk("rs_wdoe",     32'(sram_wdata_oe), 32'd0);
        chk("rs_busy",     32'(busy), 32'd0);
        chk("rs_gnt0",     32'(gnt), 32'd0);
        seen = '0;
        tick();
        seen = seen | gnt | rvalid;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | gnt | rvalid;
        end
        chk("rs_no_pulse", 32'(seen), 32'd0);
        set_req(0, 1'b1, 20'h07D00, 16'h0000);
        set_req(1, 1'b1, 20'h00030, 16'h0000);
        tick(); // T+1
        chk("rs_prio0",    32'(gnt), 32'b001);
        clr_req(0);
        tick();
        tick();
        tick(); // T+4
        chk("rs_gnt_t4",   32'(gnt), 32'd0);
        tick(); // T+5
        chk("rs_next1",    32'(gnt), 32'b010);
        clr_req(1);
        wait_idle();

        // ---- back-to-back: read then write from req0 ----
        set_req(0, 1'b1, 20'h07D00, 16'h0000);
        tick(); // T+1
        chk("bb_gnt_rd",   32'(gnt), 32'b001);
        set_req(0, 1'b0, 20'h07D01, 16'hAAAA);
        tick(); // T+2
        tick(); // T+3
        chk("bb_rvalid",   32'(rvalid), 32'b001);
        chk("bb_rdata",    32'(rdata), 32'h1234);
        tick(); // T+4
        chk("bb_gnt_t4",   32'(gnt), 32'd0);
        chk("bb_idle_t4",  32'(busy), 32'd0);
        tick(); // T+5
        chk("bb_gnt_wr",   32'(gnt), 32'b001);
        chk("bb_we_n",     32'(sram_we_n), 32'd0);
        chk("bb_addr",     32'(sram_addr), 32'h07D01);
        chk("bb_wdata",    32'(sram_wdata), 32'hAAAA);
        clr_req(0);
        tick();
        tick(); // T+7 TURN
        chk("bb_turn_st",  32'(st), 32'(S_TURN));
        chk("bb_turn_rv",  32'(rvalid), 32'd0);
        chk("bb_rdata_k",  32'(rdata), 32'h1234);
        wait_idle();

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
